// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP datapath widths, bias and normalizer state encoding
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 24;
  localparam int EXP_BIAS  = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/controlled_dec.sv
// rtl/controlled_dec.sv - enabled ripple-borrow exponent decrementer
module controlled_dec #(
  parameter int EXP_W = 8
) (
  input  logic             en,
  input  logic [EXP_W-1:0] exp_in,
  output logic [EXP_W-1:0] exp_out
);

  logic [EXP_W-1:0] borrow;

  assign borrow[0] = en;

  // Each stage is a half subtractor: difference = a ^ bin, bout = ~a & bin
  for (genvar i = 0; i < EXP_W; i++) begin : g_cell
    assign exp_out[i] = exp_in[i] ^ borrow[i];
    if (i < EXP_W - 1) begin : g_borrow
      assign borrow[i+1] = ~exp_in[i] & borrow[i];
    end
  end

endmodule

// File: rtl/fp_norm_shift_dec.sv
// rtl/fp_norm_shift_dec.sv - iterative left-shift normalizer with exponent decrement
// Optional underflow flag output guarded by FP_NORM_UNDERFLOW_EN.
module fp_norm_shift_dec
  import fp_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
`ifdef FP_NORM_UNDERFLOW_EN
  output logic              uflow,
`endif
  output logic              out_zero
);

  localparam logic [EXP_W-1:0] EXP_MIN = EXP_W'(1);

  state_t            state_q, state_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              zero_q, zero_d;
  logic [EXP_W-1:0]  exp_dec;
`ifdef FP_NORM_UNDERFLOW_EN
  logic              uflow_q, uflow_d;
`endif

  controlled_dec #(.EXP_W(EXP_W)) u_dec (
    .en      (state_q == SHIFT),
    .exp_in  (exp_q),
    .exp_out (exp_dec)
  );

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    zero_d  = zero_q;
`ifdef FP_NORM_UNDERFLOW_EN
    uflow_d = uflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = in_exp;
          mant_d  = in_mant;
          zero_d  = 1'b0;
`ifdef FP_NORM_UNDERFLOW_EN
          uflow_d = 1'b0;
`endif
          if (in_mant == '0) begin
            exp_d   = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end else if (in_exp == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (mant_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_q == EXP_MIN) begin
          // Minimum exponent reached: become denormal rather than shift further
          exp_d   = '0;
`ifdef FP_NORM_UNDERFLOW_EN
          uflow_d = 1'b1;
`endif
          state_d = DONE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_dec;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      mant_q  <= '0;
      zero_q  <= 1'b0;
`ifdef FP_NORM_UNDERFLOW_EN
      uflow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      zero_q  <= zero_d;
`ifdef FP_NORM_UNDERFLOW_EN
      uflow_q <= uflow_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_exp   = exp_q;
  assign out_mant  = mant_q;
  assign out_zero  = zero_q;
`ifdef FP_NORM_UNDERFLOW_EN
  assign uflow     = uflow_q;
`endif

endmodule

// File: tb/tb_fp_norm_shift_dec.sv
// tb/tb_fp_norm_shift_dec.sv - directed vector bench for fp_norm_shift_dec
module tb_fp_norm_shift_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_zero;
`ifdef FP_NORM_UNDERFLOW_EN
  logic        uflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_norm_shift_dec dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
`ifdef FP_NORM_UNDERFLOW_EN
    .uflow     (uflow),
`endif
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [7:0]  exp_e;
    logic [23:0] mant_e;
    logic        zero_e;
    logic        uflow_e;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, " out_valid timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_exp   = v.exp;
    in_mant  = v.mant;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(nm);
    check({nm, " exp"},  32'(out_exp),  32'(v.exp_e));
    check({nm, " mant"}, 32'(out_mant), 32'(v.mant_e));
    check({nm, " zero"}, 32'(out_zero), 32'(v.zero_e));
`ifdef FP_NORM_UNDERFLOW_EN
    check({nm, " uflow"}, 32'(uflow), 32'(v.uflow_e));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h80, 24'h800000, 8'h80, 24'h800000, 1'b0, 1'b0};
    vecs[1] = '{8'h80, 24'h100000, 8'h7D, 24'h800000, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 24'h010000, 8'h00, 24'h040000, 1'b0, 1'b1};
    vecs[3] = '{8'h45, 24'h000000, 8'h00, 24'h000000, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 24'h012345, 8'h00, 24'h012345, 1'b0, 1'b0};
    vecs[5] = '{8'h02, 24'h400000, 8'h01, 24'h800000, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 24'h400000, 8'h00, 24'h400000, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 24'h000001, 8'hE8, 24'h800000, 1'b0, 1'b0};
    vecs[8] = '{8'h10, 24'h000001, 8'h00, 24'h008000, 1'b0, 1'b1};
    vecs[9] = '{8'h80, 24'h7FFFFF, 8'h7F, 24'hFFFFFE, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    check("rst in_ready",  32'(in_ready),  32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_exp",   32'(out_exp),   32'd0);
    check("rst out_mant",  32'(out_mant),  32'd0);
    check("rst out_zero",  32'(out_zero),  32'd0);
`ifdef FP_NORM_UNDERFLOW_EN
    check("rst uflow",     32'(uflow),     32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: result held for 5 cycles while new input is offered and ignored
    @(negedge clk);
    in_exp   = 8'h80;
    in_mant  = 24'h100000;
    in_valid = 1'b1;
    @(negedge clk);
    in_exp   = 8'h45;
    in_mant  = 24'h000000;
    wait_valid("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp hold valid",    32'(out_valid), 32'd1);
      check("bp hold exp",      32'(out_exp),   32'h7D);
      check("bp hold mant",     32'(out_mant),  32'h800000);
      check("bp hold zero",     32'(out_zero),  32'd0);
      check("bp in_ready low",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp released valid", 32'(out_valid), 32'd0);
    check("bp released ready", 32'(in_ready),  32'd1);
    repeat (3) @(negedge clk);
    check("bp no spurious result", 32'(out_valid), 32'd0);

    // Reset while shifting a long run of leading zeros
    in_exp   = 8'h80;
    in_mant  = 24'h000001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid in_ready busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst out_exp",   32'(out_exp),   32'd0);
    check("mid-rst out_mant",  32'(out_mant),  32'd0);
    @(negedge clk);
    check("mid-rst in_ready",  32'(in_ready),  32'd1);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("mid-rst no result", 32'(seen), 32'd0);
    end

    run_vec(vecs[1], 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
